// File: rtl/mport_ram_pkg.sv
// Shared definitions for mport_ram: FSM state encoding, byte-enable width
// derivation and the address range check.
package mport_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic int unsigned be_w(int unsigned dw);
    return dw / 8;
  endfunction

  // Addresses are zero-extended to 32 bits by the caller.
  function automatic logic addr_ok(logic [31:0] addr, int unsigned mem_num);
    return addr < mem_num;
  endfunction

endpackage

// File: rtl/mport_ram_if.sv
// Bus bundle for mport_ram: one byte-enabled write port, RD_PORTS read ports
// (flattened per-port fields) and the clear-sweep busy flag.
interface mport_ram_if
  import mport_ram_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 12,
  parameter int unsigned RD_PORTS = 2
);

  localparam int unsigned BE_W = be_w(DW);

  logic                   wen;
  logic [BE_W-1:0]        w_be_i;
  logic [AW-1:0]          w_addr_i;
  logic [DW-1:0]          w_data_i;
  logic [RD_PORTS-1:0]    ren;
  logic [RD_PORTS*AW-1:0] r_addr_i;
  logic [RD_PORTS*DW-1:0] r_data_o;
  logic [RD_PORTS-1:0]    r_valid_o;
  logic                   init_busy_o;

  modport master (
    output wen, w_be_i, w_addr_i, w_data_i, ren, r_addr_i,
    input  r_data_o, r_valid_o, init_busy_o
  );

  modport slave (
    input  wen, w_be_i, w_addr_i, w_data_i, ren, r_addr_i,
    output r_data_o, r_valid_o, init_busy_o
  );

endinterface

// File: rtl/mport_ram_rd.sv
// One read port of mport_ram: registered read, byte-granular write forwarding
// and an optional second output stage (MPORT_RAM_OUT_REG_EN).
module mport_ram_rd
  import mport_ram_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 12,
  localparam int unsigned BeW = be_w(DW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd_en_i,
  input  logic [AW-1:0]  rd_addr_i,
  input  logic [DW-1:0]  rd_word_i,
  input  logic           wr_act_i,
  input  logic [AW-1:0]  wr_addr_i,
  input  logic [BeW-1:0] wr_be_i,
  input  logic [DW-1:0]  wr_data_i,
  output logic [DW-1:0]  rd_data_o,
  output logic           rd_valid_o
);

  logic [DW-1:0]  rdata_q;
  logic [DW-1:0]  wdata_q;
  logic [BeW-1:0] hit_q;
  logic           valid_q;
  logic [BeW-1:0] hit_d;
  logic [DW-1:0]  merged;

  // Equal addresses imply the read is in range whenever the write is.
  assign hit_d = (wr_act_i && (wr_addr_i == rd_addr_i)) ? wr_be_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      wdata_q <= '0;
      hit_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en_i;
      if (rd_en_i) begin
        rdata_q <= rd_word_i;
        wdata_q <= wr_data_i;
        hit_q   <= hit_d;
      end
    end
  end

  always_comb begin
    merged = rdata_q;
    for (int k = 0; k < int'(BeW); k++) begin
      if (hit_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

`ifdef MPORT_RAM_OUT_REG_EN
  logic [DW-1:0] out_q;
  logic          out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= valid_q;
      if (valid_q) out_q <= merged;
    end
  end

  assign rd_data_o  = out_q;
  assign rd_valid_o = out_valid_q;
`else
  assign rd_data_o  = merged;
  assign rd_valid_o = valid_q;
`endif

endmodule

// File: rtl/mport_ram.sv
// Multi-read-port RAM with byte-enabled write, per-port forwarding and a
// zeroing sweep after reset. MPORT_RAM_OUT_REG_EN adds a second read stage.
module mport_ram
  import mport_ram_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 12,
  parameter int unsigned MEM_NUM  = 4096,
  parameter int unsigned RD_PORTS = 2
) (
  input logic        clk,
  input logic        rst,
  mport_ram_if.slave bus
);

  localparam logic [AW-1:0] LastAddr = AW'(MEM_NUM - 1);

  logic [DW-1:0] mem [MEM_NUM];

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_en;
  logic          run;
  logic          wr_act;

  logic [DW-1:0] rd_data  [RD_PORTS];
  logic          rd_valid [RD_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    run     = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == LastAddr) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: run = 1'b1;
    endcase
  end

  assign wr_act          = run && bus.wen && addr_ok(32'(bus.w_addr_i), MEM_NUM);
  assign bus.init_busy_o = (state_q == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        mem[cnt_q] <= '0;
      end else if (wr_act) begin
        for (int k = 0; k < int'(DW / 8); k++) begin
          if (bus.w_be_i[k]) mem[bus.w_addr_i][8*k +: 8] <= bus.w_data_i[8*k +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < int'(RD_PORTS); p++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] word;

    assign addr = bus.r_addr_i[p*AW +: AW];
    assign word = addr_ok(32'(addr), MEM_NUM) ? mem[addr] : '0;

    mport_ram_rd #(
      .DW (DW),
      .AW (AW)
    ) u_rd (
      .clk        (clk),
      .rst        (rst),
      .rd_en_i    (run && bus.ren[p]),
      .rd_addr_i  (addr),
      .rd_word_i  (word),
      .wr_act_i   (wr_act),
      .wr_addr_i  (bus.w_addr_i),
      .wr_be_i    (bus.w_be_i),
      .wr_data_i  (bus.w_data_i),
      .rd_data_o  (rd_data[p]),
      .rd_valid_o (rd_valid[p])
    );
  end

  always_comb begin
    bus.r_data_o  = '0;
    bus.r_valid_o = '0;
    for (int p = 0; p < int'(RD_PORTS); p++) begin
      bus.r_data_o[p*DW +: DW] = rd_data[p];
      bus.r_valid_o[p]         = rd_valid[p];
    end
  end

endmodule

// File: tb/tb_mport_ram.sv
// Bench for mport_ram: two instances (16 and 12 words) share one stimulus
// stream and are compared every cycle against a word-level reference model.
module tb_mport_ram;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NP = 2;
`ifdef MPORT_RAM_OUT_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          wen;
  logic [3:0]    be;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [NP-1:0] ren;
  logic [AW-1:0] raddr [NP];

  mport_ram_if #(.DW(DW), .AW(AW), .RD_PORTS(NP)) bus0 ();
  mport_ram_if #(.DW(DW), .AW(AW), .RD_PORTS(NP)) bus1 ();

  assign bus0.wen      = wen;
  assign bus0.w_be_i   = be;
  assign bus0.w_addr_i = waddr;
  assign bus0.w_data_i = wdata;
  assign bus0.ren      = ren;
  assign bus0.r_addr_i = {raddr[1], raddr[0]};
  assign bus1.wen      = wen;
  assign bus1.w_be_i   = be;
  assign bus1.w_addr_i = waddr;
  assign bus1.w_data_i = wdata;
  assign bus1.ren      = ren;
  assign bus1.r_addr_i = {raddr[1], raddr[0]};

  mport_ram #(.DW(DW), .AW(AW), .MEM_NUM(16), .RD_PORTS(NP)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mport_ram #(.DW(DW), .AW(AW), .MEM_NUM(12), .RD_PORTS(NP)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic          busy_obs  [2];
  logic [NP-1:0] valid_obs [2];
  logic [63:0]   data_obs  [2];
  assign busy_obs[0]  = bus0.init_busy_o;
  assign busy_obs[1]  = bus1.init_busy_o;
  assign valid_obs[0] = bus0.r_valid_o;
  assign valid_obs[1] = bus1.r_valid_o;
  assign data_obs[0]  = bus0.r_data_o;
  assign data_obs[1]  = bus1.r_data_o;

  // Reference model: word arrays, remaining sweep cycles, and per-port
  // expected outputs after one and two register stages.
  logic [31:0] mm [2][16];
  int          clear_left [2];
  logic        s1v [2][NP];
  logic [31:0] s1d [2][NP];
  logic        s2v [2][NP];
  logic [31:0] s2d [2][NP];

  int total = 0;
  int bad   = 0;

  function automatic int unsigned msz(int d);
    return (d == 0) ? 16 : 12;
  endfunction

  function automatic logic [31:0] apply(logic [31:0] old, logic [3:0] b, logic [31:0] nd);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = nd[8*k +: 8];
    return r;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int unsigned ms = msz(d);
      if (rst) begin
        clear_left[d] = int'(ms);
        for (int a = 0; a < 16; a++) mm[d][a] = '0;
        for (int p = 0; p < int'(NP); p++) begin
          s1v[d][p] = 1'b0; s1d[d][p] = '0; s2v[d][p] = 1'b0; s2d[d][p] = '0;
        end
      end else begin
        for (int p = 0; p < int'(NP); p++) begin
          if (s1v[d][p]) s2d[d][p] = s1d[d][p];
          s2v[d][p] = s1v[d][p];
        end
        if (clear_left[d] > 0) begin
          clear_left[d]--;
          for (int p = 0; p < int'(NP); p++) s1v[d][p] = 1'b0;
        end else begin
          for (int p = 0; p < int'(NP); p++) begin
            s1v[d][p] = ren[p];
            if (ren[p]) begin
              if (32'(raddr[p]) >= ms) s1d[d][p] = '0;
              else if (wen && waddr == raddr[p]) s1d[d][p] = apply(mm[d][raddr[p]], be, wdata);
              else s1d[d][p] = mm[d][raddr[p]];
            end
          end
          if (wen && 32'(waddr) < ms) mm[d][waddr] = apply(mm[d][waddr], be, wdata);
        end
      end
    end
  endtask

  task automatic step(input string tag);
    logic        eb, ev;
    logic [31:0] ed;
    model_edge();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      eb = (clear_left[d] > 0);
      total++;
      assert (busy_obs[d] === eb) else begin
        bad++;
        $error("FAIL %s busy dut%0d got=%0b want=%0b", tag, d, busy_obs[d], eb);
      end
      for (int p = 0; p < int'(NP); p++) begin
`ifdef MPORT_RAM_OUT_REG_EN
        ev = s2v[d][p]; ed = s2d[d][p];
`else
        ev = s1v[d][p]; ed = s1d[d][p];
`endif
        total++;
        assert (valid_obs[d][p] === ev) else begin
          bad++;
          $error("FAIL %s valid dut%0d p%0d got=%0b want=%0b", tag, d, p, valid_obs[d][p], ev);
        end
        total++;
        assert (data_obs[d][32*p +: 32] === ed) else begin
          bad++;
          $error("FAIL %s data dut%0d p%0d got=%h want=%h", tag, d, p, data_obs[d][32*p +: 32], ed);
        end
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] v);
    wen = 1'b1; waddr = a; be = b; wdata = v; ren = '0;
    step("write");
    wen = 1'b0;
  endtask

  task automatic idle(input int n);
    wen = 1'b0; ren = '0;
    repeat (n) step("idle");
  endtask

  // Counts busy cycles after rst falls; bounded so a stuck sweep still ends.
  task automatic sweep(input string tag);
    int n0 = 0;
    int n1 = 0;
    for (int i = 0; i < 40 && (busy_obs[0] || busy_obs[1]); i++) begin
      if (busy_obs[0]) n0++;
      if (busy_obs[1]) n1++;
      ren = 2'b11; raddr[0] = AW'(i); raddr[1] = AW'(i + 1);
      step(tag);
    end
    ren = '0;
    total++;
    assert (n0 === 16) else begin bad++; $error("FAIL %s len16 got=%0d want=16", tag, n0); end
    total++;
    assert (n1 === 12) else begin bad++; $error("FAIL %s len12 got=%0d want=12", tag, n1); end
  endtask

  task automatic chk_word(input string tag, input int p, input logic [31:0] want);
    total++;
    assert (valid_obs[0][p] === 1'b1 && data_obs[0][32*p +: 32] === want) else begin
      bad++;
      $error("FAIL %s p%0d got=%h/%0b want=%h/1", tag, p, data_obs[0][32*p +: 32],
             valid_obs[0][p], want);
    end
  endtask

  initial begin
    wen = 1'b0; be = '0; waddr = '0; wdata = '0; ren = '0;
    raddr[0] = '0; raddr[1] = '0;
    repeat (2) @(posedge clk);
    #1;

    rst = 1'b1; ren = 2'b11; step("reset"); rst = 1'b0;
    sweep("sweep_first");

    for (int a = 0; a < 16; a++) wr(AW'(a), 4'hF, 32'hFFFF_FFFF);
    rst = 1'b1; step("reset_pre"); rst = 1'b0;
    sweep("sweep_clear");
    for (int a = 0; a < 16; a++) begin
      ren = 2'b11; raddr[0] = AW'(a); raddr[1] = AW'(15 - a);
      step("read_zero");
    end
    idle(LAT);

    wr(4'd5, 4'hF, 32'hAABB_CCDD);
    wr(4'd5, 4'b0101, 32'h1122_3344);
    ren = 2'b01; raddr[0] = 4'd5; step("read_be");
    ren = '0;
    repeat (LAT - 1) step("read_be_wait");
    chk_word("byte_merge", 0, 32'hAA22_CC44);

    wr(4'd7, 4'hF, 32'h1234_5678);
    wen = 1'b1; waddr = 4'd7; be = 4'b1100; wdata = 32'hDEAD_BEEF;
    ren = 2'b11; raddr[0] = 4'd7; raddr[1] = 4'd7;
    step("fwd");
    wen = 1'b0;
    repeat (LAT - 1) step("fwd_wait");
    chk_word("fwd_p0", 0, 32'hDEAD_5678);
    chk_word("fwd_p1", 1, 32'hDEAD_5678);
    step("fwd_reread");
    ren = '0;
    idle(LAT + 1);

    wr(4'd2, 4'hF, 32'h0202_0202);
    wr(4'd3, 4'hF, 32'h0303_0303);
    ren = 2'b11; raddr[0] = 4'd2; raddr[1] = 4'd3; step("indep");
    idle(4);

    wr(4'd13, 4'hF, 32'h0000_0005);
    wr(4'd11, 4'hF, 32'hCAFE_F00D);
    ren = 2'b11; raddr[0] = 4'd13; raddr[1] = 4'd11; step("bound");
    idle(LAT + 1);

    rst = 1'b1; step("reset_a"); rst = 1'b0;
    ren = 2'b11;
    repeat (6) step("clear_part");
    rst = 1'b1; step("reset_mid"); rst = 1'b0;
    sweep("sweep_mid");

    wr(4'd9, 4'hF, 32'h9999_0000);
    ren = 2'b11; raddr[0] = 4'd9; raddr[1] = 4'd9; step("pend");
    rst = 1'b1; step("reset_run"); rst = 1'b0;
    total++;
    assert (valid_obs[0] === 2'b00 && data_obs[0] === 64'h0) else begin
      bad++;
      $error("FAIL reset_run_out got=%h/%b want=0/00", data_obs[0], valid_obs[0]);
    end
    sweep("sweep_run");

    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 149) == 0);
      wen      = 1'($urandom);
      be       = 4'($urandom);
      waddr    = 4'($urandom);
      wdata    = $urandom;
      ren      = 2'($urandom);
      raddr[0] = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom);
      raddr[1] = ($urandom_range(0, 3) == 0) ? raddr[0] : 4'($urandom);
      step("rand");
    end
    rst = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mport_ram.md
Name: mport_ram

Overview:
- Parametrised multi-read-port RAM; next generation of the team's 1W/1R bypassing dual-port RAM.
- One write port with byte enables, RD_PORTS independent synchronous read ports, and per-port read-during-write forwarding merged at byte granularity.
- Clears itself to zero after reset and reports busy while clearing.
- Used as register file / scratch memory where several consumers read the same array.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 12, address width.
- MEM_NUM, 4096, number of words; MEM_NUM <= 2**AW.
- RD_PORTS, 2, number of read ports, 1..4.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- wen  input  1  write enable.
- w_be_i  input  DW/8  byte enables; bit k covers bits [8k+7:8k].
- w_addr_i  input  AW  write address.
- w_data_i  input  DW  write data.
- ren  input  RD_PORTS  read enable, one bit per port.
- r_addr_i  input  RD_PORTS*AW  read addresses; port p at [p*AW +: AW].
- r_data_o  output  RD_PORTS*DW  read data; port p at [p*DW +: DW].
- r_valid_o  output  RD_PORTS  read data valid, one bit per port.
- init_busy_o  output  1  high while the clear sweep runs.

Behaviour:
- Reset: while rst=1, the state is forced to CLEAR and the sweep counter to 0. r_data_o=0, r_valid_o=0, init_busy_o=1.
- FSM states: CLEAR and RUN.
  - CLEAR: writes 0 to address cnt each cycle and increments cnt. When cnt=MEM_NUM-1 is written, the next state is RUN.
  - RUN: the only other state; it is left only via rst.
  - Sweep length: exactly MEM_NUM cycles after rst falls. init_busy_o deasserts on the edge entering RUN.
  - Reset mid-CLEAR restarts the sweep at 0.
- During CLEAR: wen and ren are ignored, r_valid_o stays 0, and r_data_o holds 0.
- Write (RUN): if wen=1 and w_addr_i<MEM_NUM, byte k of mem[w_addr_i] takes w_data_i byte k when w_be_i[k]=1. Other bytes are unchanged. wen with w_be_i=0 is a no-op.
- Read (RUN), latency 1, per port p: if ren[p]=1, r_data_o[p] shows the word one cycle later and r_valid_o[p]=1 in that cycle.
- When ren[p]=0: r_valid_o[p]=0 next cycle, and r_data_o[p] holds its last value.
- Out-of-range read: r_addr_i>=MEM_NUM returns 0 with r_valid_o=1. Out-of-range write is dropped.
- Read-during-write forwarding: if wen=1, ren[p]=1 and r_addr_i[p]==w_addr_i in the same cycle, r_data_o[p] returns the merged word.
  - Merged word: bytes with w_be_i set come from the new w_data_i; the remaining bytes are the old memory contents.
- Forwarding implementation: register a per-port byte hit mask and the write data, then merge at the output mux.
- All ports may read the same address in the same cycle; each port forwards independently.
- Ports never stall; there is no backpressure.

Optional Feature:
- Macro: MPORT_RAM_OUT_REG_EN.
- Defined:
  - Adds a second output register stage per port: read latency 2, r_valid_o delayed identically.
  - The forwarding merge is resolved before the second stage, so the returned data is identical to the undefined case, one cycle later.
  - The stage resets to 0 and holds when its input valid is 0.
- Undefined: latency 1 as above.

Decomposition:
- Shared package mport_ram_pkg contains:
  - state encoding constants ST_CLEAR=1'b0 and ST_RUN=1'b1;
  - the BE_W=DW/8 derivation function;
  - the address range-check function.
- Sub-module mport_ram_rd: one read port.
  - Holds the registered read, the hit mask and write-data capture, the byte merge, the optional second stage, and the valid tracking.
  - Instantiated RD_PORTS times in a generate loop.
- The top level owns the memory array, the FSM/sweep counter and the write logic.

Test Plan:
- Sweep: preload mem with 0xFFFFFFFF, pulse rst one cycle (MEM_NUM=16) -> init_busy_o high exactly 16 cycles; every read of addr 0..15 returns 0x00000000.
- Byte write: write 0xAABBCCDD be=4'hF to addr 5, then 0x11223344 be=4'b0101 -> port0 reads 0xAA22CC44 at addr 5, r_valid_o[0]=1 one cycle after ren (two with MPORT_RAM_OUT_REG_EN).
- Forwarding: mem[7]=0x12345678; same cycle write 0xDEADBEEF be=4'b1100 to 7 with both ports reading 7 -> both return 0xDEAD5678; the next read returns 0xDEAD5678.
- Independent ports: port0 reads addr 2 and port1 reads addr 3 in the same cycle -> each returns its own word.
  - Then drop ren -> r_valid_o=0 and r_data_o holds the prior values.
- Boundary: MEM_NUM=12, AW=4; write 0x5 to addr 13 -> dropped; read addr 13 -> 0 with valid=1. Read addr 11 after writing it -> correct data.
- Reset mid-operation: assert rst during CLEAR at cnt=6 and again during RUN with reads pending.
  - r_valid_o=0 and r_data_o=0 the next cycle.
  - The sweep restarts and lasts MEM_NUM full cycles.
  - Reads issued during CLEAR produce no valid.
